// File: rtl/svo_stream_pkg.sv
// Shared definitions for the SVO stream blocks: scheduler state encoding,
// source IDs and the width helper used to size counters.
package svo_stream_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_PASS = 1'b1
  } smux_state_t;

  localparam logic SRC_TCARD = 1'b0;
  localparam logic SRC_FB    = 1'b1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/svo_axis_reg.sv
// One-stage AXI-stream register slice (tvalid/tready/tdata/tuser) shared by
// the SVO stream blocks. The slot reloads whenever it is empty or being drained.
module svo_axis_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tuser
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_user;

  assign s_tready = !r_valid || m_tready;
  assign m_tvalid = r_valid;
  assign m_tdata  = r_data;
  assign m_tuser  = r_user;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
    end else if (s_tready) begin
      r_valid <= s_tvalid;
      // tuser is dropped on empty loads so a stale SOF flag never lingers
      r_user  <= s_tvalid & s_tuser;
      if (s_tvalid) r_data <= s_tdata;
    end
  end

endmodule

// File: rtl/svo_stream_mux.sv
// Frame-aligned two-source scheduler for the SVO output stream with a
// starvation watchdog on source 1. Define SVO_SMUX_DRAIN_INACTIVE_EN to drain the idle source.
module svo_stream_mux
  import svo_stream_pkg::*;
#(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int TIMEOUT            = 4096
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sel_req,
  input  logic                          in0_axis_tvalid,
  output logic                          in0_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in0_axis_tdata,
  input  logic                          in0_axis_tuser,
  input  logic                          in1_axis_tvalid,
  output logic                          in1_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in1_axis_tdata,
  input  logic                          in1_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic                          active_src,
  output logic                          locked,
  output logic                          fallback
);

  localparam int               WD_W    = clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_FIRE = WD_W'(TIMEOUT - 1);

  smux_state_t r_state, w_state_nxt;
  logic        r_active_src, w_active_nxt;
  logic        r_fallback, w_fallback_nxt;
  logic [WD_W-1:0] r_wd, w_wd_nxt;

  logic                          w_load;
  logic                          w_act_valid;
  logic                          w_act_sof;
  logic                          w_act_ready;
  logic [SVO_BITS_PER_PIXEL-1:0] w_act_data;
  logic                          w_eff_sel;
  logic                          w_starved;
  logic                          w_beat;
  logic                          w_idle_ready;

`ifdef SVO_SMUX_DRAIN_INACTIVE_EN
  assign w_idle_ready = 1'b1;
`else
  assign w_idle_ready = 1'b0;
`endif

  assign w_act_valid = (r_active_src == SRC_FB) ? in1_axis_tvalid : in0_axis_tvalid;
  assign w_act_sof   = (r_active_src == SRC_FB) ? in1_axis_tuser  : in0_axis_tuser;
  assign w_act_data  = (r_active_src == SRC_FB) ? in1_axis_tdata  : in0_axis_tdata;

  // After a watchdog fallback, a request for source 1 is ignored until sel_req drops.
  assign w_eff_sel = sel_req & ~r_fallback;
  assign w_starved = (r_active_src == SRC_FB) && !in1_axis_tvalid &&
                     ((r_state == ST_SYNC) || w_load);
  assign w_beat    = (r_state == ST_PASS) && w_act_valid && w_act_ready;

  assign in0_axis_tready = (r_active_src == SRC_TCARD) ? w_act_ready : w_idle_ready;
  assign in1_axis_tready = (r_active_src == SRC_FB)    ? w_act_ready : w_idle_ready;

  assign active_src = r_active_src;
  assign locked     = (r_state == ST_PASS);
  assign fallback   = r_fallback;

  always_comb begin
    w_state_nxt    = r_state;
    w_active_nxt   = r_active_src;
    w_fallback_nxt = r_fallback & sel_req;
    w_wd_nxt       = r_wd;
    w_act_ready    = 1'b0;
    case (r_state)
      ST_SYNC: begin
        // Discard until SOF; the SOF beat itself is held for PASS to take.
        w_act_ready = !w_act_sof;
        if (w_eff_sel != r_active_src)      w_active_nxt = w_eff_sel;
        else if (w_act_valid && w_act_sof)  w_state_nxt  = ST_PASS;
      end
      default: begin
        if (w_act_valid && w_act_sof && (w_eff_sel != r_active_src)) begin
          w_active_nxt = w_eff_sel;
          w_state_nxt  = ST_SYNC;
        end else begin
          w_act_ready = w_load;
        end
      end
    endcase
    // Watchdog is evaluated last so it overrides a same-cycle SOF switch.
    if ((r_active_src != SRC_FB) || in1_axis_tvalid) begin
      w_wd_nxt = '0;
    end else if (w_starved) begin
      if (r_wd == WD_FIRE) begin
        w_active_nxt   = SRC_TCARD;
        w_fallback_nxt = 1'b1;
        w_state_nxt    = ST_SYNC;
        w_wd_nxt       = '0;
      end else begin
        w_wd_nxt = r_wd + 1'b1;
      end
    end
    if (w_active_nxt != r_active_src) w_wd_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_SYNC;
      r_active_src <= SRC_TCARD;
      r_fallback   <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_src <= w_active_nxt;
      r_fallback   <= w_fallback_nxt;
      r_wd         <= w_wd_nxt;
    end
  end

  svo_axis_reg #(
    .DATA_W (SVO_BITS_PER_PIXEL)
  ) u_out_reg (
    .clk      (clk),
    .resetn   (resetn),
    .s_tvalid (w_beat),
    .s_tready (w_load),
    .s_tdata  (w_act_data),
    .s_tuser  (w_act_sof),
    .m_tvalid (out_axis_tvalid),
    .m_tready (out_axis_tready),
    .m_tdata  (out_axis_tdata),
    .m_tuser  (out_axis_tuser)
  );

endmodule
